// File: rtl/lcd_bus_arbiter.sv
// HD44780-style character LCD bus owner: runs the power-up wait and the init
// command sequence after reset, then serves two write requesters round-robin,
// generating setup/enable/hold strobes and the post-write execution wait.
module lcd_bus_arbiter #(
    parameter int unsigned SETUP_CYC    = 4,
    parameter int unsigned EN_CYC       = 12,
    parameter int unsigned HOLD_CYC     = 4,
    parameter int unsigned CMD_WAIT_CYC = 2700,
    parameter int unsigned CLR_WAIT_CYC = 108000,
    parameter int unsigned PWRUP_CYC    = 5400000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_IDLE,
        S_SETUP,
        S_ENABLE,
        S_HOLD,
        S_WAIT
    } state_t;

    localparam logic [31:0] L_PWRUP_LAST = 32'(PWRUP_CYC - 1);
    localparam logic [31:0] L_SETUP_LAST = 32'(SETUP_CYC - 1);
    localparam logic [31:0] L_EN_LAST    = 32'(EN_CYC - 1);
    localparam logic [31:0] L_HOLD_LAST  = 32'(HOLD_CYC - 1);
    localparam logic [31:0] L_CMD_LAST   = 32'(CMD_WAIT_CYC - 1);
    localparam logic [31:0] L_CLR_LAST   = 32'(CLR_WAIT_CYC - 1);

    state_t      r_state;
    logic [31:0] r_cnt;
    logic [1:0]  r_idx;
    logic        r_init_phase;
    logic        r_init_done;
    logic        r_last_gnt1;   // 1: req1 was granted last, so req0 wins a tie
    logic        r_rs;
    logic        r_en;
    logic [7:0]  r_data;

    state_t      w_state_nxt;
    logic [31:0] w_cnt_nxt;
    logic [1:0]  w_idx_nxt;
    logic [1:0]  w_idx_inc;
    logic        w_init_phase_nxt;
    logic        w_init_done_nxt;
    logic        w_last_gnt1_nxt;
    logic        w_rs_nxt;
    logic [7:0]  w_data_nxt;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_is_clr;
    logic [31:0] w_wait_last;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h01;
            2'd2:    init_byte = 8'h0C;
            default: init_byte = 8'h06;
        endcase
    endfunction

    assign w_idx_inc   = r_idx + 2'd1;
    // Clear (0x01) and return-home (0x02/0x03) commands need the long wait.
    assign w_is_clr    = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02) || (r_data == 8'h03));
    assign w_wait_last = w_is_clr ? L_CLR_LAST : L_CMD_LAST;

    // Next-state, counter, payload and round-robin grant logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt + 32'd1;
        w_idx_nxt        = r_idx;
        w_init_phase_nxt = r_init_phase;
        w_init_done_nxt  = r_init_done;
        w_last_gnt1_nxt  = r_last_gnt1;
        w_rs_nxt         = r_rs;
        w_data_nxt       = r_data;
        w_gnt0           = 1'b0;
        w_gnt1           = 1'b0;

        case (r_state)
            S_PWRUP: begin
                if (r_cnt == L_PWRUP_LAST) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 2'd0;
                    w_rs_nxt    = 1'b0;
                    w_data_nxt  = init_byte(2'd0);
                end
            end
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (r_init_done) begin
                    if (req0_valid && (!req1_valid || r_last_gnt1)) begin
                        w_gnt0 = 1'b1;
                    end else if (req1_valid) begin
                        w_gnt1 = 1'b1;
                    end
                end
                if (w_gnt0) begin
                    w_state_nxt     = S_SETUP;
                    w_rs_nxt        = req0_rs;
                    w_data_nxt      = req0_data;
                    w_last_gnt1_nxt = 1'b0;
                end else if (w_gnt1) begin
                    w_state_nxt     = S_SETUP;
                    w_rs_nxt        = req1_rs;
                    w_data_nxt      = req1_data;
                    w_last_gnt1_nxt = 1'b1;
                end
            end
            S_SETUP: begin
                if (r_cnt == L_SETUP_LAST) begin
                    w_state_nxt = S_ENABLE;
                    w_cnt_nxt   = '0;
                end
            end
            S_ENABLE: begin
                if (r_cnt == L_EN_LAST) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                end
            end
            S_HOLD: begin
                if (r_cnt == L_HOLD_LAST) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT: begin
                if (r_cnt == w_wait_last) begin
                    w_cnt_nxt = '0;
                    if (r_init_phase) begin
                        if (r_idx == 2'd3) begin
                            w_state_nxt      = S_IDLE;
                            w_init_phase_nxt = 1'b0;
                            w_init_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_SETUP;
                            w_idx_nxt   = w_idx_inc;
                            w_rs_nxt    = 1'b0;
                            w_data_nxt  = init_byte(w_idx_inc);
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_PWRUP;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered LCD bus outputs; reset abandons any write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_PWRUP;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_init_phase <= 1'b1;
            r_init_done  <= 1'b0;
            r_last_gnt1  <= 1'b1;
            r_rs         <= 1'b0;
            r_en         <= 1'b0;
            r_data       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_init_phase <= w_init_phase_nxt;
            r_init_done  <= w_init_done_nxt;
            r_last_gnt1  <= w_last_gnt1_nxt;
            r_rs         <= w_rs_nxt;
            r_en         <= (w_state_nxt == S_ENABLE);
            r_data       <= w_data_nxt;
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign init_done  = r_init_done;
    assign busy       = (r_state != S_IDLE);
    assign lcd_rs     = r_rs;
    assign lcd_rw     = 1'b0;
    assign lcd_en     = r_en;
    assign lcd_data   = r_data;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter: init sequence timing, round-robin
// arbitration table, clear/home wait lengths and asynchronous reset abort.
module tb_lcd_bus_arbiter;

    localparam int unsigned P_SETUP = 2;
    localparam int unsigned P_EN    = 3;
    localparam int unsigned P_HOLD  = 2;
    localparam int unsigned P_CMD   = 5;
    localparam int unsigned P_CLR   = 20;
    localparam int unsigned P_PWRUP = 50;
    localparam int          SP_N    = P_SETUP + P_EN + P_HOLD + P_CMD + 1;   // 13
    localparam int          SP_C    = P_SETUP + P_EN + P_HOLD + P_CLR + 1;   // 28

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_rs, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_rs, req1_ready;
    logic [7:0] req1_data;
    logic       init_done, busy, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;

    lcd_bus_arbiter #(
        .SETUP_CYC    (P_SETUP),
        .EN_CYC       (P_EN),
        .HOLD_CYC     (P_HOLD),
        .CMD_WAIT_CYC (P_CMD),
        .CLR_WAIT_CYC (P_CLR),
        .PWRUP_CYC    (P_PWRUP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_rs    (req0_rs),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_rs    (req1_rs),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .init_done  (init_done),
        .busy       (busy),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_en     (lcd_en),
        .lcd_data   (lcd_data)
    );

    always #5 clk = ~clk;

    int cyc    = 0;
    int rw_bad = 0;
    int n_vec  = 0;
    int n_err  = 0;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (lcd_rw !== 1'b0) rw_bad++;

    typedef struct {
        logic [7:0] data;
        int         gap;
    } init_rec_t;

    typedef struct {
        logic       v0;
        logic       rs0;
        logic [7:0] d0;
        logic       v1;
        logic       rs1;
        logic [7:0] d1;
        int         who;
        logic       exp_rs;
        logic [7:0] exp_data;
        int         spacing;
    } vec_t;

    init_rec_t init_tab[4];
    vec_t      tab[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Starts at the negedge where reset was released; ends at the first IDLE negedge.
    task automatic init_seq();
        int  k;
        int  w;
        bit  ready_seen;
        bit  done_early;
        ready_seen = 1'b0;
        done_early = 1'b0;
        k = 0;
        while (lcd_en !== 1'b1 && k < int'(P_PWRUP + P_SETUP) + 20) begin
            @(negedge clk);
            k++;
            if (req0_ready || req1_ready) ready_seen = 1'b1;
            if (init_done === 1'b1) done_early = 1'b1;
        end
        check("pwrup_first_en", k, P_PWRUP + P_SETUP);
        for (int i = 0; i < 4; i++) begin
            check("init_rs", lcd_rs, 1'b0);
            check("init_data", lcd_data, init_tab[i].data);
            w = 0;
            while (lcd_en === 1'b1 && w < 50) begin
                @(negedge clk);
                w++;
                if (req0_ready || req1_ready) ready_seen = 1'b1;
            end
            check("init_en_width", w, P_EN);
            w = 0;
            if (i < 3) begin
                while (lcd_en !== 1'b1 && w < 100) begin
                    @(negedge clk);
                    w++;
                    if (req0_ready || req1_ready) ready_seen = 1'b1;
                    if (init_done === 1'b1) done_early = 1'b1;
                end
            end else begin
                while (init_done !== 1'b1 && w < 100) begin
                    @(negedge clk);
                    w++;
                    if ((req0_ready || req1_ready) && init_done !== 1'b1) ready_seen = 1'b1;
                end
            end
            check("init_gap", w, init_tab[i].gap);
        end
        check("init_done_busy", busy, 1'b0);
        check("init_done_en", lcd_en, 1'b0);
        check("ready_during_init", ready_seen, 1'b0);
        check("init_done_early", done_early, 1'b0);
    endtask

    // Called at the negedge where an accept is visible; follows the write to en rise.
    task automatic check_write(input logic exp_rs, input logic [7:0] exp_data);
        @(negedge clk);
        check("ready_one_pulse", {req0_ready, req1_ready}, 2'b00);
        check("setup_en_low", lcd_en, 1'b0);
        check("setup_rs", lcd_rs, exp_rs);
        check("setup_data", lcd_data, exp_data);
        @(negedge clk);
        check("setup_en_low2", lcd_en, 1'b0);
        @(negedge clk);
        check("en_rise", lcd_en, 1'b1);
        check("en_rs", lcd_rs, exp_rs);
        check("en_data", lcd_data, exp_data);
    endtask

    initial begin
        int w;
        int who;
        int prev_acc;
        bit found;

        init_tab[0] = '{8'h38, P_HOLD + P_CMD + P_SETUP};
        init_tab[1] = '{8'h01, P_HOLD + P_CLR + P_SETUP};
        init_tab[2] = '{8'h0C, P_HOLD + P_CMD + P_SETUP};
        init_tab[3] = '{8'h06, P_HOLD + P_CMD};

        //          v0    rs0   d0     v1    rs1   d1    who rs    data   spacing
        tab[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h52, 1, 1'b1, 8'h52, SP_N};
        tab[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h53, 1, 1'b1, 8'h53, SP_N};
        tab[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1, 1'b0, 8'h01, SP_N};
        tab[3]  = '{1'b1, 1'b1, 8'hA0, 1'b1, 1'b1, 8'hB0, 0, 1'b1, 8'hA0, SP_C};
        tab[4]  = '{1'b1, 1'b1, 8'hA0, 1'b1, 1'b1, 8'hB0, 1, 1'b1, 8'hB0, SP_N};
        tab[5]  = '{1'b1, 1'b1, 8'hA0, 1'b1, 1'b1, 8'hB0, 0, 1'b1, 8'hA0, SP_N};
        tab[6]  = '{1'b1, 1'b1, 8'hA0, 1'b1, 1'b1, 8'hB0, 1, 1'b1, 8'hB0, SP_N};
        tab[7]  = '{1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h02, SP_N};
        tab[8]  = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h01, SP_C};
        tab[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 1, 1'b0, 8'h03, SP_N};
        tab[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h04, 1, 1'b0, 8'h04, SP_C};
        tab[11] = '{1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 8'hC0, 0, 1'b0, 8'h80, SP_N};

        reset      = 1'b1;
        req0_valid = 1'b0; req0_rs = 1'b0; req0_data = 8'h00;
        req1_valid = 1'b0; req1_rs = 1'b0; req1_data = 8'h00;

        repeat (3) @(negedge clk);
        check("reset_state",
              {lcd_rs, lcd_en, lcd_data, init_done, busy, req0_ready, req1_ready},
              {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});

        // Power-up and init with no requesters active.
        reset = 1'b0;
        init_seq();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_busy", busy, 1'b0);
        end

        // Start a write, then pull reset while the enable strobe is high.
        @(posedge clk);
        #1;
        req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h55;
        w = 0;
        while (lcd_en !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("pre_reset_en", lcd_en, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async_en_drop", lcd_en, 1'b0);
        check("async_busy", busy, 1'b1);
        check("async_init_done", init_done, 1'b0);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h43;
        @(negedge clk);
        reset = 1'b0;

        // Full power-up/init reruns while req0 waits with valid held high.
        init_seq();
        check("first_idle_ready0", req0_ready, 1'b1);
        check("first_idle_ready1", req1_ready, 1'b0);
        prev_acc = cyc;
        check_write(1'b1, 8'h43);

        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            req0_valid = tab[i].v0; req0_rs = tab[i].rs0; req0_data = tab[i].d0;
            req1_valid = tab[i].v1; req1_rs = tab[i].rs1; req1_data = tab[i].d1;
            found = 1'b0;
            who   = -1;
            w     = 0;
            while (!found && w < 200) begin
                @(negedge clk);
                w++;
                if (req0_ready && req0_valid) begin
                    found = 1'b1;
                    who   = 0;
                end else if (req1_ready && req1_valid) begin
                    found = 1'b1;
                    who   = 1;
                end
            end
            if (!found) begin
                n_vec++;
                n_err++;
                $display("FAIL accept_timeout: vector %0d got no accept within 200 cycles", i);
            end else begin
                check("grant_who", who, tab[i].who);
                check("both_ready", {req0_ready, req1_ready}, (tab[i].who == 0) ? 2'b10 : 2'b01);
                check("accept_spacing", cyc - prev_acc, tab[i].spacing);
                prev_acc = cyc;
                check_write(tab[i].exp_rs, tab[i].exp_data);
            end
        end

        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("rw_always_low", rw_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Owns the HD44780-style character LCD bus (lcd_rs, lcd_rw, lcd_en, lcd_data) and shares it between two write requesters, e.g. the time display and a set-mode/alarm message writer.
- After reset it runs the power-up wait and the fixed init command sequence on its own.
- It then serves {rs,data} write requests round-robin, generating setup / enable / hold timing and the post-write execution wait for each one.
- Requesters never touch LCD timing themselves.

Parameters:
- SETUP_CYC, 4: cycles rs/data are stable before lcd_en rises (min 1).
- EN_CYC, 12: cycles lcd_en is held high (min 1).
- HOLD_CYC, 4: cycles rs/data are held after lcd_en falls (min 1).
- CMD_WAIT_CYC, 2700: execution wait after a normal write (50 us at 54 MHz).
- CLR_WAIT_CYC, 108000: execution wait after clear/home commands (2 ms).
- PWRUP_CYC, 5400000: delay from reset release to the first init command (100 ms).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has a write pending
- req0_rs  in  1  requester 0 register select (0 = command, 1 = data)
- req0_data  in  8  requester 0 byte
- req0_ready  out  1  requester 0 write accepted this cycle
- req1_valid  in  1  requester 1 has a write pending
- req1_rs  in  1  requester 1 register select
- req1_data  in  8  requester 1 byte
- req1_ready  out  1  requester 1 write accepted this cycle
- init_done  out  1  init sequence complete; stays high until reset
- busy  out  1  bus transaction or wait in progress
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write; tied 0 (write only)
- lcd_en  out  1  LCD enable strobe
- lcd_data  out  8  LCD data bus

Behaviour:
- Reset values: lcd_rs=0, lcd_en=0, lcd_data=0, init_done=0, busy=1, req0_ready=0, req1_ready=0. Round-robin pointer favours req0 first. State = PWRUP.
- Reset asserted mid-transaction: lcd_en drops to 0 asynchronously, the in-flight write is abandoned (never retried), and the full power-up and init sequence reruns.
- lcd_en, lcd_rs and lcd_data are registered outputs. The internal cycle counter is 32 bits.
- States: PWRUP, IDLE, SETUP, ENABLE, HOLD, WAIT.
- Internal flag init_phase and a 2-bit init index i.
- PWRUP: counts PWRUP_CYC cycles. It then loads init byte i=0 with rs=0 and enters SETUP.
- Init bytes, in order: 0x38, 0x01, 0x0C, 0x06.
- SETUP: rs/data driven, lcd_en=0, for SETUP_CYC cycles, then ENABLE.
- ENABLE: lcd_en=1 for EN_CYC cycles, then HOLD.
- HOLD: lcd_en=0, rs/data unchanged, for HOLD_CYC cycles, then WAIT.
- WAIT length:
  - CLR_WAIT_CYC if the latched byte has rs=0 and data is 0x01, 0x02 or 0x03 (clear or home).
  - CMD_WAIT_CYC otherwise.
- Leaving WAIT:
  - During init with i<3: i increments, the next init byte loads, go to SETUP.
  - During init with i==3: init_done is set and the state goes to IDLE.
  - Otherwise: go to IDLE.
- lcd_rs/lcd_data keep their last values in WAIT and IDLE.
- busy = 1 in every state except IDLE.
- IDLE grant (combinational, only when init_done=1):
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted last time wins.
- reqN_ready = grant N in IDLE. This is a one-cycle pulse; transfer happens on valid & ready.
- On accept: rs/data latch into the output registers on the next edge, state goes to SETUP, and the round-robin pointer updates.
- Requests are ignored while not IDLE or while init_done=0. Requesters hold valid and payload until ready.
- Accept-to-accept minimum spacing: SETUP_CYC+EN_CYC+HOLD_CYC+wait+1 cycles.
- lcd_en rises exactly SETUP_CYC+1 cycles after the accept edge.
- A requester whose valid drops before it is granted loses nothing. No request is queued.

Test Plan (bench parameters SETUP=2, EN=3, HOLD=2, CMD_WAIT=5, CLR_WAIT=20, PWRUP=50):
- Release reset, no requests -> lcd_en stays 0 for 50 cycles; then four en pulses, each 3 cycles high, carrying 0x38, 0x01, 0x0C, 0x06 with rs=0; a 20-cycle wait after 0x01 and 5 after the others; then init_done=1 and busy=0.
- req0 holds valid from t=0 -> req0_ready stays 0 until init_done; exactly one ready pulse in the first IDLE cycle; 0x43 appears with rs=1 and lcd_en rises 3 cycles after the accept edge.
- req0 and req1 both continuously valid, data 0xA0 and 0xB0 -> accepts alternate 0, 1, 0, 1 starting with req0; accept spacing is 13 cycles.
- req1 writes rs=0, data 0x01 after init -> WAIT lasts 20 cycles; the next accept comes 28 cycles after the prior one.
- Assert reset while lcd_en=1 -> lcd_en=0 in the same cycle; after release, a full 50-cycle PWRUP and the init sequence repeat.
- Only req1 valid, repeatedly -> every write is granted to req1 with no idle gap beyond the timing; lcd_rw stays 0 throughout.
